// File: rtl/soc_simple_pll_reset_seq.sv
// soc_simple_pll_reset_seq: PLL reset sequencing with lock qualification, timeout retry and status counters
module soc_simple_pll_reset_seq #(
  parameter int SYNC_STAGES        = 2,
  parameter int PLL_RST_CYCLES     = 16,
  parameter int LOCK_TIMEOUT       = 65536,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int CNT_W              = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             locked,
  input  logic             soft_reset,
  output logic             pll_rst,
  output logic             sys_rst,
  output logic             pll_ok,
  output logic [CNT_W-1:0] relock_cnt,
  output logic [CNT_W-1:0] timeout_cnt
);
  localparam int MAX_AB = PLL_RST_CYCLES > LOCK_TIMEOUT ? PLL_RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_C  = MAX_AB > LOCK_STABLE_CYCLES ? MAX_AB : LOCK_STABLE_CYCLES;
  localparam int CW     = MAX_C > 1 ? $clog2(MAX_C) : 1;
  typedef enum logic [1:0] {PLL_RESET, WAIT_LOCK, STABILIZE, RUN} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [SYNC_STAGES-1:0] sync;
  logic locked_s, relock_inc, timeout_inc;
  assign locked_s = sync[SYNC_STAGES-1];
  always_comb begin
    state_n     = state;
    cnt_n       = cnt + 1'b1;
    relock_inc  = 1'b0;
    timeout_inc = 1'b0;
    if (soft_reset) begin
      state_n = PLL_RESET;
      cnt_n   = '0;
    end else begin
      case (state)
        PLL_RESET: if (cnt == CW'(PLL_RST_CYCLES - 1)) begin
          state_n = WAIT_LOCK;
          cnt_n   = '0;
        end
        WAIT_LOCK: if (locked_s) begin
          state_n = STABILIZE;
          cnt_n   = '0;
        end else if (cnt == CW'(LOCK_TIMEOUT - 1)) begin
          state_n     = PLL_RESET;
          cnt_n       = '0;
          timeout_inc = 1'b1;
        end
        STABILIZE: if (!locked_s) begin
          state_n = WAIT_LOCK;
          cnt_n   = '0;
        end else if (cnt == CW'(LOCK_STABLE_CYCLES - 1)) begin
          state_n = RUN;
          cnt_n   = '0;
        end
        RUN: begin
          cnt_n = '0;
          if (!locked_s) begin
            state_n    = WAIT_LOCK;
            relock_inc = 1'b1;
          end
        end
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= PLL_RESET;
      cnt         <= '0;
      sync        <= '0;
      pll_rst     <= 1'b1;
      sys_rst     <= 1'b1;
      pll_ok      <= 1'b0;
      relock_cnt  <= '0;
      timeout_cnt <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      sync    <= {sync[SYNC_STAGES-2:0], locked};
      pll_rst <= state_n == PLL_RESET;
      sys_rst <= state_n != RUN;
      pll_ok  <= state_n == RUN;
      if (relock_inc && !(&relock_cnt)) relock_cnt <= relock_cnt + 1'b1;
      if (timeout_inc && !(&timeout_cnt)) timeout_cnt <= timeout_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_soc_simple_pll_reset_seq.sv
// tb_soc_simple_pll_reset_seq: directed scenarios against a timestamp-based sequencing model
module tb_soc_simple_pll_reset_seq;
  localparam int P = 4, LT = 32, LS = 8;
  logic clk = 0, rst = 1, locked = 0, soft_reset = 0;
  logic pll_rst, sys_rst, pll_ok;
  logic [7:0] relock_cnt, timeout_cnt;
  soc_simple_pll_reset_seq #(.SYNC_STAGES(2), .PLL_RST_CYCLES(P), .LOCK_TIMEOUT(LT),
    .LOCK_STABLE_CYCLES(LS), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .locked(locked), .soft_reset(soft_reset), .pll_rst(pll_rst),
    .sys_rst(sys_rst), .pll_ok(pll_ok), .relock_cnt(relock_cnt), .timeout_cnt(timeout_cnt));
  always #10 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int vecs = 0, errs = 0;
  // model: phase 0 pll reset, 1 wait, 2 stabilize, 3 run; t0 is the edge the phase began
  int ph = 0, t0 = 0, mt = 0, rc = 0, tc = 0;
  bit h0 = 0, h1 = 0, mvalid = 0, ls = 0;
  always @(posedge clk) begin
    mt++;
    if (rst) begin
      ph = 0; t0 = mt; rc = 0; tc = 0; h0 = 0; h1 = 0; mvalid = 1;
    end else begin
      ls = h1; h1 = h0; h0 = locked;
      if (soft_reset) begin
        ph = 0; t0 = mt;
      end else if (ph == 0) begin
        if (mt - t0 == P) begin ph = 1; t0 = mt; end
      end else if (ph == 1) begin
        if (ls) begin ph = 2; t0 = mt; end
        else if (mt - t0 == LT) begin ph = 0; t0 = mt; tc = tc < 255 ? tc + 1 : 255; end
      end else if (ph == 2) begin
        if (!ls) begin ph = 1; t0 = mt; end
        else if (mt - t0 == LS) begin ph = 3; t0 = mt; end
      end else if (!ls) begin
        ph = 1; t0 = mt; rc = rc < 255 ? rc + 1 : 255;
      end
    end
  end
  always @(negedge clk) if (mvalid) begin
    vecs++;
    if ({pll_rst, sys_rst, pll_ok, relock_cnt, timeout_cnt} !==
        {ph == 0, ph != 3, ph == 3, rc[7:0], tc[7:0]}) begin
      errs++;
      $display("FAIL model cyc=%0d: got pll_rst=%b sys_rst=%b pll_ok=%b relock=%0d timeout=%0d, want %b %b %b %0d %0d",
        cyc, pll_rst, sys_rst, pll_ok, relock_cnt, timeout_cnt, ph == 0, ph != 3, ph == 3, rc, tc);
    end
  end
  task automatic chk(input string n, input int a, input int e);
    vecs++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", n, a, e);
    end
  endtask
  task automatic wait_fall(input string n, input int start, input int exp, output int prst);
    prst = 0;
    for (int k = 0; k < 60 && sys_rst; k++) begin
      @(negedge clk);
      prst += int'(pll_rst);
    end
    chk(n, sys_rst ? -1 : cyc - start, exp);
  endtask
  initial begin
    int n, s, f, prev, rises, first, last, lows, prst;
    // power-up
    repeat (3) @(negedge clk);
    rst = 0; n = 0; s = 0;
    for (int i = 0; i < 8; i++) begin
      if (i == 5) begin locked = 1; s = cyc + 1; end
      n += int'(pll_rst);
      @(negedge clk);
    end
    chk("pwrup_pll_rst_len", n, 4);
    wait_fall("pwrup_release_edges", s, 10, prst);
    chk("pwrup_pll_ok", int'(pll_ok), 1);
    chk("pwrup_relock_cnt", int'(relock_cnt), 0);
    chk("pwrup_timeout_cnt", int'(timeout_cnt), 0);
    // no lock
    locked = 0; rst = 1;
    @(negedge clk);
    rst = 0; prev = 1; rises = 0; first = -1; last = -1; lows = 0;
    for (int j = 1; j <= 200; j++) begin
      @(negedge clk);
      if (pll_rst && prev == 0) begin rises++; if (first < 0) first = j; last = j; end
      prev = int'(pll_rst);
      lows += int'(!sys_rst);
      if (j == 180) chk("nolock_timeout_cnt_180", int'(timeout_cnt), 5);
    end
    chk("nolock_pulses", rises, 5);
    chk("nolock_first_pulse", first, 36);
    chk("nolock_last_pulse", last, 180);
    chk("nolock_sys_rst_low", lows, 0);
    // unstable lock
    lows = 0;
    for (int i = 0; i < 7; i++) begin
      locked = i < 5;
      @(negedge clk);
      lows += int'(!sys_rst);
    end
    locked = 1; s = cyc + 1;
    chk("burst_no_release", lows, 0);
    wait_fall("unstable_release_edges", s, 10, prst);
    // lock loss in RUN
    locked = 0; f = cyc + 1;
    @(negedge clk);
    @(negedge clk);
    chk("loss_f1_sys_rst", int'(sys_rst), 0);
    @(negedge clk);
    chk("loss_f2_edge", cyc - f, 2);
    chk("loss_sys_rst", int'(sys_rst), 1);
    chk("loss_pll_ok", int'(pll_ok), 0);
    chk("loss_relock_cnt", int'(relock_cnt), 1);
    locked = 1; s = cyc + 1;
    wait_fall("relock_release_edges", s, 10, prst);
    chk("relock_no_pll_rst", prst, 0);
    // soft reset in RUN
    soft_reset = 1;
    @(negedge clk);
    soft_reset = 0;
    chk("soft_sys_rst", int'(sys_rst), 1);
    n = 0;
    for (int i = 0; i < 8; i++) begin
      n += int'(pll_rst);
      @(negedge clk);
    end
    chk("soft_pll_rst_len", n, 4);
    chk("soft_relock_cnt", int'(relock_cnt), 1);
    chk("soft_timeout_cnt", int'(timeout_cnt), 5);
    wait_fall("soft_release_edges", cyc, 5, prst);
    // soft reset coincident with locked_s fall
    locked = 0;
    @(negedge clk);
    @(negedge clk);
    soft_reset = 1;
    @(negedge clk);
    soft_reset = 0;
    chk("coinc_pll_rst", int'(pll_rst), 1);
    chk("coinc_sys_rst", int'(sys_rst), 1);
    repeat (3) @(negedge clk);
    chk("coinc_relock_cnt", int'(relock_cnt), 1);
    // saturation then reset mid-stabilize
    repeat (300 * 36) @(negedge clk);
    chk("sat_timeout_cnt", int'(timeout_cnt), 255);
    locked = 1;
    repeat (8) @(negedge clk);
    chk("stab_sys_rst", int'(sys_rst), 1);
    chk("stab_pll_rst", int'(pll_rst), 0);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("rst_pll_rst", int'(pll_rst), 1);
    chk("rst_sys_rst", int'(sys_rst), 1);
    chk("rst_pll_ok", int'(pll_ok), 0);
    chk("rst_relock_cnt", int'(relock_cnt), 0);
    chk("rst_timeout_cnt", int'(timeout_cnt), 0);
    repeat (20) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
